// File: rtl/wb_gpio_irq.sv
// Wishbone B3 classic GPIO slave: per-bit direction, synchronised inputs,
// atomic set/clear of outputs and per-bit edge interrupts folded onto irq_o.
module wb_gpio_irq #(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [2:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  typedef enum logic [2:0] {
    REG_DATA_OUT = 3'd0,
    REG_DIR      = 3'd1,
    REG_DATA_IN  = 3'd2,
    REG_IRQ_EN   = 3'd3,
    REG_IRQ_EDGE = 3'd4,
    REG_IRQ_STAT = 3'd5,
    REG_OUT_SET  = 3'd6,
    REG_OUT_CLR  = 3'd7
  } reg_addr_e;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] irq_edge_q, irq_edge_d;
  logic [WIDTH-1:0] irq_stat_q, irq_stat_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic             ack_q, ack_d;
  logic             irq_q, irq_d;
  logic [31:0]      dat_q, dat_d;

  reg_addr_e        addr;
  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] wr_mask, wr_data, data_in, rise, fall, irq_event;
  logic [WIDTH-1:0] w1c_mask, rd_val;
  logic [31:0]      rd_data;
  logic             access, write;
  logic             unused_bits;

  assign addr      = reg_addr_e'(wb_adr_i);
  assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wr_mask   = lane_mask[WIDTH-1:0];
  assign wr_data   = wb_dat_i[WIDTH-1:0] & wr_mask;
  // The ~ack term gives the single wait state and one ack per access.
  assign access    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign write     = access & wb_we_i;

  assign data_in   = sync_q[SYNC_STAGES-1];
  assign rise      = data_in & ~prev_q;
  assign fall      = ~data_in & prev_q;
  assign irq_event = irq_en_q & ((irq_edge_q & rise) | (~irq_edge_q & fall));

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    rd_val = '0;
    case (addr)
      REG_DATA_OUT: rd_val = data_out_q;
      REG_DIR:      rd_val = dir_q;
      REG_DATA_IN:  rd_val = data_in;
      REG_IRQ_EN:   rd_val = irq_en_q;
      REG_IRQ_EDGE: rd_val = irq_edge_q;
      REG_IRQ_STAT: rd_val = irq_stat_q;
      default:      rd_val = '0;
    endcase
    rd_data              = '0;
    rd_data[WIDTH-1:0]   = rd_val;
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    irq_edge_d = irq_edge_q;
    w1c_mask   = '0;
    if (write) begin
      case (addr)
        REG_DATA_OUT: data_out_d = (data_out_q & ~wr_mask) | wr_data;
        REG_DIR:      dir_d      = (dir_q & ~wr_mask) | wr_data;
        REG_IRQ_EN:   irq_en_d   = (irq_en_q & ~wr_mask) | wr_data;
        REG_IRQ_EDGE: irq_edge_d = (irq_edge_q & ~wr_mask) | wr_data;
        REG_IRQ_STAT: w1c_mask   = wr_data;
        REG_OUT_SET:  data_out_d = data_out_q | wr_data;
        REG_OUT_CLR:  data_out_d = data_out_q & ~wr_data;
        default:      ;
      endcase
    end
    // A new event outranks a clear of the same bit in the same cycle.
    irq_stat_d = (irq_stat_q & ~w1c_mask) | irq_event;
    irq_d      = |irq_stat_q;
    ack_d      = access;
    dat_d      = access ? rd_data : dat_q;
    sync_d[0]  = gpio_i;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d     = data_in;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      data_out_q <= RESET_OUT;
      dir_q      <= RESET_DIR;
      irq_en_q   <= '0;
      irq_edge_q <= '0;
      irq_stat_q <= '0;
      prev_q     <= '0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
      dat_q      <= '0;
      // NOTE: the synchroniser array is a handful of flops, not a RAM, so it
      // is reset explicitly to keep spurious edges out of the first cycles.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      irq_edge_q <= irq_edge_d;
      irq_stat_q <= irq_stat_d;
      prev_q     <= prev_d;
      ack_q      <= ack_d;
      irq_q      <= irq_d;
      dat_q      <= dat_d;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = 1'b0;
  assign wb_rty_o  = 1'b0;
  assign gpio_o    = data_out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = irq_q;

  // Burst hints and data lanes above WIDTH have no function in this slave.
  assign unused_bits = ^{wb_cti_i, wb_bte_i, wb_dat_i, lane_mask};

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench: an 8-bit and a 32-bit instance share one bus and the
// pins, each compared every cycle against a register-level reference model.
module tb_wb_gpio_irq;
  localparam int SS = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, cyc, stb;
  logic [2:0]  adr, cti;
  logic [1:0]  bte;
  logic [3:0]  sel;
  logic [31:0] wdat, pins;

  logic [31:0] dat8, dat32, gpo32, oe32;
  logic [7:0]  gpo8, oe8;
  logic        ack8, ack32, err8, err32, rty8, rty32, irq8, irq32;

  wb_gpio_irq #(.WIDTH(8), .SYNC_STAGES(SS), .RESET_OUT(8'hA5), .RESET_DIR(8'hFF)) dut8 (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat8), .wb_ack_o(ack8), .wb_err_o(err8), .wb_rty_o(rty8),
    .gpio_i(pins[7:0]), .gpio_o(gpo8), .gpio_oe_o(oe8), .irq_o(irq8));

  wb_gpio_irq #(.WIDTH(32), .SYNC_STAGES(SS), .RESET_OUT(32'h1234_00A5), .RESET_DIR(32'h0)) dut32 (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat32), .wb_ack_o(ack32), .wb_err_o(err32), .wb_rty_o(rty32),
    .gpio_i(pins), .gpio_o(gpo32), .gpio_oe_o(oe32), .irq_o(irq32));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: architectural registers per instance, pin history as a queue.
  typedef struct packed {
    logic [31:0] dout, dir, en, edg, stat, dat;
    logic        irq, ack;
  } mstate_t;

  mstate_t     m [2];
  logic [31:0] wmask   [2] = '{32'h0000_00FF, 32'hFFFF_FFFF};
  logic [31:0] rst_out [2] = '{32'h0000_00A5, 32'h1234_00A5};
  logic [31:0] rst_dir [2] = '{32'h0000_00FF, 32'h0000_0000};
  logic [31:0] pin_hist [$];

  function automatic logic [31:0] read_reg(input mstate_t s, input logic [2:0] a,
                                           input logic [31:0] din);
    case (a)
      3'd0:    return s.dout;
      3'd1:    return s.dir;
      3'd2:    return din;
      3'd3:    return s.en;
      3'd4:    return s.edg;
      3'd5:    return s.stat;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] din, prv, rise, fall, ev, bm, wd, w1c;
    logic        acc;
    mstate_t     nx;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m[k] = '0;
        m[k].dout = rst_out[k];
        m[k].dir  = rst_dir[k];
      end
      pin_hist.delete();
      repeat (SS + 1) pin_hist.push_back(32'h0);
      return;
    end
    din  = pin_hist[SS-1];
    prv  = pin_hist[SS];
    rise = din & ~prv;
    fall = ~din & prv;
    for (int k = 0; k < 2; k++) begin
      nx  = m[k];
      acc = cyc & stb & ~m[k].ack;
      bm  = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}} & wmask[k];
      wd  = wdat & bm;
      w1c = 32'h0;
      ev  = m[k].en & ((m[k].edg & rise) | (~m[k].edg & fall));
      nx.irq = (m[k].stat != 0);
      nx.ack = acc;
      if (acc) nx.dat = read_reg(m[k], adr, din & wmask[k]);
      if (acc && we) begin
        case (adr)
          3'd0: nx.dout = (m[k].dout & ~bm) | wd;
          3'd1: nx.dir  = (m[k].dir & ~bm) | wd;
          3'd3: nx.en   = (m[k].en & ~bm) | wd;
          3'd4: nx.edg  = (m[k].edg & ~bm) | wd;
          3'd5: w1c     = wd;
          3'd6: nx.dout = m[k].dout | wd;
          3'd7: nx.dout = m[k].dout & ~wd;
          default: ;
        endcase
      end
      nx.stat = (m[k].stat & ~w1c) | ev;
      m[k] = nx;
    end
    pin_hist.push_front(pins);
    void'(pin_hist.pop_back());
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("ack8",   {31'h0, ack8},  {31'h0, m[0].ack});
    check("ack32",  {31'h0, ack32}, {31'h0, m[1].ack});
    check("dat8",   dat8,           m[0].dat);
    check("dat32",  dat32,          m[1].dat);
    check("gpo8",   {24'h0, gpo8},  m[0].dout);
    check("gpo32",  gpo32,          m[1].dout);
    check("oe8",    {24'h0, oe8},   m[0].dir);
    check("oe32",   oe32,           m[1].dir);
    check("irq8",   {31'h0, irq8},  {31'h0, m[0].irq});
    check("irq32",  {31'h0, irq32}, {31'h0, m[1].irq});
    check("err_rty", {28'h0, err8, rty8, err32, rty32}, 32'h0);
  endtask

  task automatic wb_xfer(input logic [2:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r8, output logic [31:0] r32);
    int waits = 0;
    adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    cti = 3'($urandom); bte = 2'($urandom);
    cycle();
    while (!ack8 && waits < 4) begin
      cycle();
      waits++;
    end
    check("ack_latency", waits, 0);
    r8 = dat8; r32 = dat32;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    cycle();
  endtask

  logic [31:0] r8, r32;

  initial begin
    repeat (SS + 1) pin_hist.push_back(32'h0);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
    cti = '0; bte = '0; pins = '0;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    check("rst_gpo8", {24'h0, gpo8}, 32'hA5);
    check("rst_oe8",  {24'h0, oe8},  32'hFF);
    check("rst_irq",  {31'h0, irq8}, 32'h0);
    check("rst_ack",  {31'h0, ack8}, 32'h0);
    wb_xfer(3'd5, 1'b0, 32'h0, 4'hF, r8, r32);
    check("rst_stat", r8, 32'h0);

    wb_xfer(3'd0, 1'b1, 32'h0F, 4'hF, r8, r32);
    wb_xfer(3'd6, 1'b1, 32'hF0, 4'hF, r8, r32);
    wb_xfer(3'd7, 1'b1, 32'h03, 4'hF, r8, r32);
    check("setclr_gpo8", {24'h0, gpo8}, 32'hFC);

    wb_xfer(3'd1, 1'b1, 32'hFFFF_FFFF, 4'b0001, r8, r32);
    check("sel_dir32", oe32, 32'h0000_00FF);
    wb_xfer(3'd6, 1'b0, 32'h0, 4'hF, r8, r32);
    check("rd_outset", r32, 32'h0);

    wb_xfer(3'd3, 1'b1, 32'h1, 4'hF, r8, r32);
    wb_xfer(3'd4, 1'b1, 32'h1, 4'hF, r8, r32);
    pins = 32'h1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      check("irq_latency", {31'h0, irq8}, (i == 4) ? 32'h1 : 32'h0);
    end
    wb_xfer(3'd2, 1'b0, 32'h0, 4'hF, r8, r32);
    check("data_in", r8, 32'h1);
    wb_xfer(3'd5, 1'b1, 32'h1, 4'hF, r8, r32);
    check("w1c_irq", {31'h0, irq8}, 32'h0);
    pins = 32'h0;
    repeat (4) cycle();
    wb_xfer(3'd5, 1'b0, 32'h0, 4'hF, r8, r32);
    check("fall_ignored", r8, 32'h0);
    pins = 32'h1;
    cycle(); cycle();
    wb_xfer(3'd5, 1'b1, 32'h1, 4'hF, r8, r32);
    wb_xfer(3'd5, 1'b0, 32'h0, 4'hF, r8, r32);
    check("event_beats_clear", r8, 32'h1);

    wb_xfer(3'd3, 1'b1, 32'h3, 4'hF, r8, r32);
    wb_xfer(3'd4, 1'b1, 32'h3, 4'hF, r8, r32);
    pins = 32'h0; repeat (4) cycle();
    pins = 32'h3; repeat (4) cycle();
    wb_xfer(3'd5, 1'b0, 32'h0, 4'hF, r8, r32);
    check("stat_two_bits", r8, 32'h3);
    adr = 3'd5; we = 1'b0; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
    cycle();
    check("midrst_ack", {31'h0, ack8}, 32'h0);
    check("midrst_irq", {31'h0, irq8}, 32'h0);
    rst = 1'b0;
    cycle();
    check("postrst_ack", {31'h0, ack8}, 32'h1);
    check("postrst_stat", dat8, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    cycle();

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      cyc  = ($urandom_range(0, 9) < 7);
      stb  = ($urandom_range(0, 9) < 7);
      we   = 1'($urandom);
      adr  = 3'($urandom);
      sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      wdat = $urandom;
      cti  = 3'($urandom);
      bte  = 2'($urandom);
      if ($urandom_range(0, 5) == 0) pins = $urandom;
      cycle();
    end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
